// File: rtl/ysyx_25020047_dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready slave serving LSU loads and byte-masked stores.
// Define DMEM_RAND_LAT_EN to add LFSR-driven random extra response latency (0..7 cycles).
module ysyx_25020047_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state_q, state_d;
   logic           wr_q;
   logic [31:0]    addr_q;
   logic [31:0]    wdata_q;
   logic [3:0]     wmask_q;
   logic [4:0]     cnt_q;
   logic [4:0]     lat;
   logic           accept;
   logic           access;
   logic [31:0]    offset;
   logic           in_range;
   logic [AW-1:0]  idx;
   logic [31:0]    mem [DEPTH_WORDS];

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = (state_q == S_RESP);
   assign accept     = req_valid && req_ready;

   // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
   assign offset   = addr_q - BASE_ADDR;
   assign in_range = offset < SPAN;
   assign idx      = offset[AW+1:2];

`ifdef DMEM_RAND_LAT_EN
   logic [7:0] lfsr_q;

   // Fibonacci LFSR for x^8+x^6+x^5+x^4+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= 8'hA5;
      else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign lat = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};
`else
   assign lat = 5'(LATENCY);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      access  = 1'b0;
      case (state_q)
         S_IDLE: if (accept) state_d = S_WAIT;
         S_WAIT: begin
            if (cnt_q == 5'd0) begin
               access  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         cnt_q      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cnt_q   <= lat;
         end else if (state_q == S_WAIT && cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
         end
         if (access) begin
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !wr_q) ? mem[idx] : 32'd0;
         end
      end
   end

   // NOTE: the array is deliberately not reset; a reset in WAIT keeps state_q out of S_WAIT, dropping the write.
   always_ff @(posedge clk) begin
      if (access && wr_q && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_dmem_responder.sv
// Directed bench for ysyx_25020047_dmem_responder: store/load, byte strobes, range errors,
// backpressure and reset behaviour; latency window widens when DMEM_RAND_LAT_EN is defined.
module tb_ysyx_25020047_dmem_responder;

   localparam int unsigned LAT = 1;
`ifdef DMEM_RAND_LAT_EN
   localparam int unsigned LAT_MAX = LAT + 8;
`else
   localparam int unsigned LAT_MAX = LAT + 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   ysyx_25020047_dmem_responder #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h8000_0000),
      .LATENCY    (LAT)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request and return 1 time unit after the accepting edge, scrambling the inputs.
   task automatic send_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
      int n = 0;
      @(negedge clk);
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = ~wr;
      req_addr  = 32'hFFFF_FFF0;
      req_wdata = 32'h5A5A_5A5A;
      req_wmask = 4'hF;
   endtask

   // Counts clock edges from the accepting edge until resp_valid is seen.
   task automatic wait_resp(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!resp_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("resp_seen", 32'(resp_valid), 32'd1);
   endtask

   task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int cyc;
      send_req(wr, a, d, m);
      wait_resp(cyc);
      check({tag, "_lat_ok"}, 32'(cyc >= int'(LAT + 1) && cyc <= int'(LAT_MAX)), 32'd1);
      check({tag, "_rdata"}, resp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      int          cyc;
      logic [31:0] pat [8];

      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wmask  = '0;
      resp_ready = 1'b0;

      // Reset state
      #12;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Word and byte store/load, zero-mask store
      txn("wr_word", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
      txn("rd_word", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      txn("wr_byte", 1'b1, 32'h8000_0012, 32'h00AB_0000, 4'h4, 32'd0, 1'b0);
      txn("rd_byte", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAB_BEEF, 1'b0);
      txn("wr_nomask", 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
      txn("rd_nomask", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAB_BEEF, 1'b0);
      txn("wr_lanes", 1'b1, 32'h8000_0014, 32'h1122_3344, 4'h9, 32'd0, 1'b0);
      txn("rd_lanes", 1'b0, 32'h8000_0014, 32'd0, 4'h0, 32'h1100_0044, 1'b0);

      // Range boundaries: first word, last word, just below, just above (which would alias word 0)
      txn("wr_w0", 1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 32'd0, 1'b0);
      txn("wr_last", 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
      txn("rd_below", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1);
      txn("wr_above", 1'b1, 32'h8000_1000, 32'hBAAD_BAAD, 4'hF, 32'd0, 1'b1);
      txn("rd_last", 1'b0, 32'h8000_0FFC, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0);
      txn("rd_w0", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 32'h0123_4567, 1'b0);

      // Backpressure: response held for 5 cycles while a competing store is offered
      send_req(1'b0, 32'h8000_0010, 32'd0, 4'h0);
      wait_resp(cyc);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h8000_0010;
      req_wdata = 32'h0000_0000;
      req_wmask = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_rdata", resp_rdata, 32'hDEAB_BEEF);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("bp_idle_after", 32'(req_ready), 32'd1);
      txn("rd_after_bp", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'hDEAB_BEEF, 1'b0);

      // Async reset while a response is pending
      send_req(1'b0, 32'h8000_0000, 32'd0, 4'h0);
      wait_resp(cyc);
      check("pend_rdata", resp_rdata, 32'h0123_4567);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(resp_valid), 32'd0);
      check("arst_rdata", resp_rdata, 32'd0);
      check("arst_err", 32'(resp_err), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_req_ready_after", 32'(req_ready), 32'd1);

      // Reset while a store sits in WAIT: the store is dropped
      txn("wr_old", 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 32'd0, 1'b0);
      send_req(1'b1, 32'h8000_0020, 32'h2222_2222, 4'hF);
      #2;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("wrst_no_resp", 32'(resp_valid), 32'd0);
      txn("rd_old", 1'b0, 32'h8000_0020, 32'd0, 4'h0, 32'h1111_1111, 1'b0);

      // Back-to-back traffic: 8 stores then 100 loads, latency checked on each
      for (int i = 0; i < 8; i++) begin
         pat[i] = 32'hA5A5_A5A5 ^ (32'h0101_0101 * 32'(i));
         txn("bulk_wr", 1'b1, 32'h8000_0100 + 32'(4 * i), pat[i], 4'hF, 32'd0, 1'b0);
      end
      for (int i = 0; i < 100; i++) begin
         txn("bulk_rd", 1'b0, 32'h8000_0100 + 32'(4 * (i % 8)), 32'd0, 4'h0, pat[i % 8], 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
